uart_vga_writer: RTL and testbench
==================================

Name: uart_vga_writer

Overview:
- Frame-level writer that fills the UART debug display RAM (uart_vga_ram) from a received UART byte stream.
- Parses framed packets (header, row index, 20 data bytes, checksum) and buffers the whole row.
- Commits the row to the RAM write port only after the checksum is verified, so the display never shows a partial or corrupt row.
- Sits between the UART RX byte interface and the write side of uart_vga_ram; the VGA renderer reads the other side.

Parameters:
- HEADER, 8'hA5, start-of-frame byte.
- BYTES, 20, data bytes per row (160-bit RAM row).
- ROWS, 46, number of valid rows (0..ROWS-1); the remaining screen lines are background.
- TIMEOUT, 100000, max idle clocks between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid; byte accepted when rx_valid && rx_ready.
- rx_ready  out  1  writer can accept a byte.
- write_address  out  32  RAM byte address = row*BYTES + k.
- ram_in  out  8  RAM write data; byte k maps to row bits [159-8k -: 8].
- we  out  1  RAM write enable.
- frame_ok  out  1  one-cycle pulse: row committed.
- frame_err  out  1  one-cycle pulse: frame discarded.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst=0):
  - State IDLE.
  - Outputs: write_address=0, ram_in=0, we=0, frame_ok=0, frame_err=0, busy=0, rx_ready=1.
  - Buffer contents are don't-care; byte counter, checksum and timeout counter are cleared.
  - Reset mid-WRITE stops writes immediately; the partially written row is not restored.
- State machine (registered; all outputs registered):
  - IDLE: accept bytes; a byte equal to HEADER moves to ROW; any other byte is dropped silently.
  - ROW: on the accepted byte, if value >= ROWS then go to IDLE and pulse frame_err; otherwise latch row, chk=row, k=0, and go to DATA.
  - DATA: on each accepted byte, buf[k]=byte, chk^=byte, k++; after byte BYTES-1, go to CHK.
  - CHK: on the accepted byte, if byte==chk go to WRITE with k=0; otherwise go to IDLE and pulse frame_err.
  - WRITE: rx_ready=0. For BYTES consecutive cycles, drive we=1, write_address=row*BYTES+k, ram_in=buf[k], k++. The cycle after the last write, drive we=0, pulse frame_ok, and go to IDLE.
- Latency: the first we=1 cycle is the first clock after the checksum byte is accepted. The commit occupies exactly BYTES cycles, and frame_ok follows one cycle later.
- HEADER inside ROW/DATA/CHK is treated as ordinary data; no resynchronisation mid-frame.
- Timeout:
  - In ROW/DATA/CHK, the counter increments every cycle without an accepted byte and clears on each accepted byte.
  - Reaching TIMEOUT forces IDLE with a frame_err pulse.
  - The counter is held at 0 in IDLE and WRITE.
- rx_ready:
  - Rules: rx_ready=1 in IDLE, ROW, DATA and CHK; rx_ready=0 in WRITE.
  - UART RX must hold a byte while rx_ready=0. At least one byte of RX-side buffering is required upstream.
- Arithmetic: write_address is computed in 32 bits, with zero-extended row*BYTES+k; max value (ROWS-1)*BYTES+BYTES-1 = 919.
- Error pulses: frame_ok and frame_err never assert in the same cycle. A new frame may start the cycle after frame_ok/frame_err.
- Abort rule: on frame_err, no RAM writes occur for that frame; we stays 0 throughout.

Test Plan:
1. Good frame: A5, 03, bytes 01..14 (hex), chk=03^01^…^14 → we high 20 cycles, addresses 60..79, ram_in 01..14 in order, then frame_ok pulse once, busy low next cycle.
2. Bad checksum: same frame with chk^8'h01 → frame_err pulse one cycle after the checksum byte; we never asserts; next good frame to row 0 writes addresses 0..19.
3. Row out of range: A5, 2E (row 46) → frame_err after the row byte, back to IDLE; the following 20 bytes are dropped until the next A5.
4. Garbage and embedded header: 00, FF, 5A then A5, 00, 20 bytes all A5, chk=00 → leading bytes ignored; 20 writes of A5 to addresses 0..19; frame_ok.
5. Timeout: A5, 01, 5 data bytes, then rx_valid low for TIMEOUT cycles → frame_err exactly at TIMEOUT; no writes; a subsequent full frame succeeds.
6. Backpressure and reset: hold rx_valid high during WRITE → rx_ready=0 for 20 cycles, no byte lost; assert rst low at write k=10 → we=0 immediately, all outputs at reset values, IDLE after release.

Source files
------------

// File: rtl/uart_vga_writer.sv
// uart_vga_writer: turns a framed UART byte stream into whole-row writes on
// the display RAM. A row is buffered in full and only committed to the RAM
// after its checksum matches, so the screen never shows a torn or corrupt row.
// Frame: HEADER, row, BYTES data bytes, checksum (row ^ all data bytes).
module uart_vga_writer #(
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         BYTES   = 20,
    parameter int         ROWS    = 46,
    parameter int         TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active low
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] write_address,
    output logic [7:0]  ram_in,
    output logic        we,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        busy
);

    // k counts up to BYTES (one past the last index) during the commit
    localparam int KW = $clog2(BYTES + 1);
    localparam int AW = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_DATA,
        ST_CHK,
        ST_WRITE
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [7:0]    row_q, row_d;
    logic [7:0]    chk_q, chk_d;
    logic [31:0]   tmo_q, tmo_d;

    logic [31:0]   addr_q, addr_d;
    logic [7:0]    ram_in_q, ram_in_d;
    logic          we_q, we_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          rx_ready_q, rx_ready_d;

    // Row staging buffer; contents are don't-care until a frame fills it
    logic [7:0]    row_buf_q [BYTES];
    logic          buf_we;

    logic          accept;
    logic [31:0]   row_base;
    logic [AW-1:0] buf_idx;

    assign accept   = rx_valid && rx_ready_q;
    assign row_base = 32'(row_q) * 32'(BYTES);
    assign buf_idx  = k_q[AW-1:0];

    // Next-state and registered-output computation for the frame parser
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        row_d    = row_q;
        chk_d    = chk_q;
        tmo_d    = 32'd0;
        addr_d   = addr_q;
        ram_in_d = ram_in_q;
        we_d     = 1'b0;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        buf_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // anything other than the header is dropped silently
                if (accept && rx_data == HEADER) begin
                    state_d = ST_ROW;
                end
            end

            ST_ROW: begin
                if (accept) begin
                    if (rx_data >= 8'(ROWS)) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        row_d   = rx_data;
                        chk_d   = rx_data;
                        k_d     = '0;
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                // header value is ordinary payload here: no mid-frame resync
                if (accept) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ rx_data;
                    k_d    = k_q + KW'(1);
                    if (k_q == KW'(BYTES - 1)) begin
                        state_d = ST_CHK;
                    end
                end
            end

            ST_CHK: begin
                if (accept) begin
                    if (rx_data == chk_q) begin
                        // first write goes out on the very next cycle, so
                        // buffer entry 0 is issued here and k points at 1
                        state_d  = ST_WRITE;
                        we_d     = 1'b1;
                        addr_d   = row_base;
                        ram_in_d = row_buf_q[0];
                        k_d      = KW'(1);
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                if (k_q < KW'(BYTES)) begin
                    we_d     = 1'b1;
                    addr_d   = row_base + 32'(k_q);
                    ram_in_d = row_buf_q[buf_idx];
                    k_d      = k_q + KW'(1);
                end else begin
                    ok_d    = 1'b1;
                    k_d     = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Inter-byte watchdog: only runs while a frame is being received
        if ((state_q == ST_ROW || state_q == ST_DATA || state_q == ST_CHK) && !accept) begin
            if (tmo_q + 32'd1 >= 32'(TIMEOUT)) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
                tmo_d   = 32'd0;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end

        // status outputs are registered from the state being entered
        rx_ready_d = (state_d != ST_WRITE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State, counters and all outputs; reset stops any commit at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            row_q      <= 8'd0;
            chk_q      <= 8'd0;
            tmo_q      <= 32'd0;
            addr_q     <= 32'd0;
            ram_in_q   <= 8'd0;
            we_q       <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rx_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            row_q      <= row_d;
            chk_q      <= chk_d;
            tmo_q      <= tmo_d;
            addr_q     <= addr_d;
            ram_in_q   <= ram_in_d;
            we_q       <= we_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    // Row buffer fill, one byte per accepted data byte
    always_ff @(posedge clk) begin
        if (buf_we) begin
            row_buf_q[buf_idx] <= rx_data;
        end
    end

    assign rx_ready      = rx_ready_q;
    assign write_address = addr_q;
    assign ram_in        = ram_in_q;
    assign we            = we_q;
    assign frame_ok      = ok_q;
    assign frame_err     = err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_vga_writer.sv
// Testbench for uart_vga_writer: directed frames with cycle-exact checks,
// then a randomized byte stream compared against a frame-level parser model.
module tb_uart_vga_writer;

    localparam logic [7:0] HEADER  = 8'hA5;
    localparam int         BYTES   = 20;
    localparam int         ROWS    = 46;
    localparam int         TIMEOUT = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] write_address;
    logic [7:0]  ram_in;
    logic        we;
    logic        frame_ok;
    logic        frame_err;
    logic        busy;

    uart_vga_writer #(
        .HEADER (HEADER),
        .BYTES  (BYTES),
        .ROWS   (ROWS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .write_address(write_address),
        .ram_in       (ram_in),
        .we           (we),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } wr_t;

    int   n_checks = 0;
    int   n_errors = 0;

    // observed activity, recorded by the monitor
    wr_t  obs_q[$];
    int   ok_cnt = 0;
    int   err_cnt = 0;
    int   excl_viol = 0;
    int   we_ready_viol = 0;

    // model side
    logic [7:0] stim_q[$];
    wr_t  exp_q[$];
    int   exp_ok;
    int   exp_err;

    logic [7:0] frame_data [BYTES];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples outputs on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            if (we) obs_q.push_back('{addr: write_address, data: 32'(ram_in)});
            if (frame_ok) ok_cnt <= ok_cnt + 1;
            if (frame_err) err_cnt <= err_cnt + 1;
            if (frame_ok && frame_err) excl_viol <= excl_viol + 1;
            if (we && rx_ready) we_ready_viol <= we_ready_viol + 1;
        end
    end

    // Present one byte; returns 1 time unit after the edge that accepted it
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check_val("ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_body(input logic [7:0] row, input logic [7:0] corrupt);
        logic [7:0] c;
        c = row;
        send_byte(row);
        for (int j = 0; j < BYTES; j++) begin
            send_byte(frame_data[j]);
            c = c ^ frame_data[j];
        end
        send_byte(c ^ corrupt);
    endtask

    task automatic send_frame(input logic [7:0] row, input logic [7:0] corrupt);
        send_byte(HEADER);
        send_body(row, corrupt);
    endtask

    // Check nwr consecutive write cycles, starting now
    task automatic expect_commit(input int row, input int nwr);
        for (int j = 0; j < nwr; j++) begin
            check_val($sformatf("we_k%0d", j), 32'(we), 32'd1);
            check_val($sformatf("addr_k%0d", j), write_address, 32'(row * BYTES + j));
            check_val($sformatf("data_k%0d", j), 32'(ram_in), 32'(frame_data[j]));
            check_val($sformatf("ready_k%0d", j), 32'(rx_ready), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic expect_done();
        check_val("done_we", 32'(we), 32'd0);
        check_val("done_ok", 32'(frame_ok), 32'd1);
        check_val("done_err", 32'(frame_err), 32'd0);
        @(posedge clk); #1;
        check_val("after_ok_busy", 32'(busy), 32'd0);
        check_val("after_ok_pulse", 32'(frame_ok), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_we"}, 32'(we), 32'd0);
        check_val({tag, "_addr"}, write_address, 32'd0);
        check_val({tag, "_ram_in"}, 32'(ram_in), 32'd0);
        check_val({tag, "_ok"}, 32'(frame_ok), 32'd0);
        check_val({tag, "_err"}, 32'(frame_err), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_ready"}, 32'(rx_ready), 32'd1);
    endtask

    // Frame-level reference parser over the whole sent byte stream
    task automatic run_model();
        int i;
        int n;
        int r;
        logic [7:0] c;
        i = 0;
        n = stim_q.size();
        exp_q.delete();
        exp_ok = 0;
        exp_err = 0;
        while (i < n) begin
            if (stim_q[i] != HEADER) begin
                i++;
            end else begin
                i++;
                if (i >= n) break;
                r = int'(stim_q[i]);
                i++;
                if (r >= ROWS) begin
                    exp_err++;
                end else begin
                    if (i + BYTES >= n) break;
                    c = 8'(r);
                    for (int j = 0; j < BYTES; j++) c = c ^ stim_q[i + j];
                    if (stim_q[i + BYTES] == c) begin
                        exp_ok++;
                        for (int j = 0; j < BYTES; j++)
                            exp_q.push_back('{addr: r * BYTES + j, data: 32'(stim_q[i + j])});
                    end else begin
                        exp_err++;
                    end
                    i += BYTES + 1;
                end
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        stim_q.push_back(b);
        send_byte(b);
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr_base;
        int ok_base;
        int err_base;
        int first_err;
        logic [7:0] c;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // ---- 1: good frame to row 3, bytes 01..14 ----
        for (int j = 0; j < BYTES; j++) frame_data[j] = 8'(j + 1);
        send_byte(HEADER);
        check_val("busy_after_hdr", 32'(busy), 32'd1);
        send_body(8'd3, 8'd0);
        expect_commit(3, BYTES);
        expect_done();
        $display("tx good frame row 3 committed");

        // ---- 2: bad checksum, then good frame to row 0 ----
        wr_base = obs_q.size();
        send_frame(8'd3, 8'h01);
        check_val("badchk_err", 32'(frame_err), 32'd1);
        check_val("badchk_we", 32'(we), 32'd0);
        check_val("badchk_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check_val("badchk_err_pulse", 32'(frame_err), 32'd0);
        check_val("badchk_no_writes", 32'(obs_q.size()), 32'(wr_base));
        $display("tx bad checksum frame discarded");
        send_frame(8'd0, 8'd0);
        expect_commit(0, BYTES);
        expect_done();
        $display("tx good frame row 0 committed");

        // ---- 3: row out of range, trailing bytes dropped ----
        wr_base  = obs_q.size();
        ok_base  = ok_cnt;
        err_base = err_cnt;
        send_byte(HEADER);
        send_byte(8'h2E);
        check_val("badrow_err", 32'(frame_err), 32'd1);
        check_val("badrow_busy", 32'(busy), 32'd0);
        for (int j = 0; j < BYTES; j++) send_byte(8'(j + 1));
        check_val("badrow_idle", 32'(busy), 32'd0);
        check_val("badrow_no_writes", 32'(obs_q.size()), 32'(wr_base));
        check_val("badrow_no_ok", 32'(ok_cnt), 32'(ok_base));
        check_val("badrow_one_err", 32'(err_cnt), 32'(err_base + 1));
        $display("tx row 46 frame rejected");

        // ---- 4: garbage then frame full of header values ----
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check_val("garbage_idle", 32'(busy), 32'd0);
        for (int j = 0; j < BYTES; j++) frame_data[j] = HEADER;
        send_byte(HEADER);
        send_byte(8'h00);
        for (int j = 0; j < BYTES; j++) send_byte(HEADER);
        send_byte(8'h00);
        expect_commit(0, BYTES);
        expect_done();
        $display("tx embedded-header frame row 0 committed");

        // ---- 5: timeout after 5 data bytes ----
        wr_base = obs_q.size();
        send_byte(HEADER);
        send_byte(8'h01);
        for (int j = 0; j < 5; j++) send_byte(8'(8'h30 + j));
        first_err = -1;
        for (int cyc = 1; cyc <= TIMEOUT + 10; cyc++) begin
            @(posedge clk); #1;
            if (frame_err && first_err < 0) first_err = cyc;
        end
        check_val("timeout_cycle", 32'(first_err), 32'(TIMEOUT));
        check_val("timeout_idle", 32'(busy), 32'd0);
        check_val("timeout_no_writes", 32'(obs_q.size()), 32'(wr_base));
        $display("tx timed-out frame aborted");
        for (int j = 0; j < BYTES; j++) frame_data[j] = 8'($urandom);
        send_frame(8'd45, 8'd0);
        expect_commit(45, BYTES);
        expect_done();
        $display("tx good frame row 45 committed");

        // ---- 6: backpressure during commit, then reset mid-commit ----
        for (int j = 0; j < BYTES; j++) frame_data[j] = 8'($urandom);
        send_frame(8'd7, 8'd0);
        fork
            begin
                expect_commit(7, BYTES);
                check_val("bp_ok", 32'(frame_ok), 32'd1);
                check_val("bp_ready_back", 32'(rx_ready), 32'd1);
            end
            send_byte(HEADER);
        join
        check_val("bp_header_kept", 32'(busy), 32'd1);
        $display("tx row 7 committed under backpressure");
        for (int j = 0; j < BYTES; j++) frame_data[j] = 8'($urandom);
        send_body(8'd5, 8'd0);
        expect_commit(5, 10);
        check_val("pre_reset_we", 32'(we), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("post_reset_busy", 32'(busy), 32'd0);
        check_val("post_reset_we", 32'(we), 32'd0);
        $display("tx row 5 commit interrupted by reset");
        for (int j = 0; j < BYTES; j++) frame_data[j] = 8'($urandom);
        send_frame(8'd9, 8'd0);
        expect_commit(9, BYTES);
        expect_done();
        $display("tx good frame row 9 committed");

        // ---- randomized stream vs frame-level model ----
        wr_base  = obs_q.size();
        ok_base  = ok_cnt;
        err_base = err_cnt;
        stim_q.delete();
        for (int f = 0; f < 40; f++) begin
            int kind;
            int row;
            kind = int'($urandom_range(0, 9));
            if (kind <= 7) begin
                row = int'($urandom_range(0, ROWS - 1));
                push_byte(HEADER);
                push_byte(8'(row));
                c = 8'(row);
                for (int j = 0; j < BYTES; j++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    c = c ^ d;
                    push_byte(d);
                end
                if (kind >= 6) c = c ^ (8'd1 << $urandom_range(0, 7));
                push_byte(c);
                $display("rnd frame %0d row %0d %s", f, row, (kind >= 6) ? "bad-chk" : "good");
            end else if (kind == 8) begin
                row = int'($urandom_range(ROWS, 255));
                push_byte(HEADER);
                push_byte(8'(row));
                $display("rnd frame %0d row %0d out-of-range", f, row);
            end else begin
                int ng;
                ng = int'($urandom_range(1, 3));
                for (int g = 0; g < ng; g++) begin
                    logic [7:0] d;
                    d = 8'($urandom_range(0, 254));
                    if (d == HEADER) d = 8'h00;
                    push_byte(d);
                end
                $display("rnd frame %0d garbage %0d bytes", f, ng);
            end
        end
        repeat (BYTES + 10) @(posedge clk);
        #1;
        run_model();
        check_val("rnd_nwrites", 32'(obs_q.size() - wr_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && (wr_base + i) < obs_q.size(); i++) begin
            check_val($sformatf("rnd_addr%0d", i), obs_q[wr_base + i].addr, exp_q[i].addr);
            check_val($sformatf("rnd_data%0d", i), obs_q[wr_base + i].data, exp_q[i].data);
        end
        check_val("rnd_ok_count", 32'(ok_cnt - ok_base), 32'(exp_ok));
        check_val("rnd_err_count", 32'(err_cnt - err_base), 32'(exp_err));
        check_val("ok_err_exclusive", 32'(excl_viol), 32'd0);
        check_val("we_while_ready", 32'(we_ready_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
